// File: rtl/regs_mp.sv
// ----------------------------------------------------------------------------
// regs_mp
//
// Multi-port integer register file that sits between the decode/issue stage
// (reads and scoreboard marking) and the writeback stage. It provides:
//   - NUM_RD combinational read ports, with optional write-through bypass
//   - two write ports: wb (writeback, highest priority) and ld (late load)
//   - a per-entry pending-write scoreboard ("busy" bits)
//   - a post-reset clear walk that zeroes one entry per cycle, so the
//     storage array itself carries no reset
// Entry 0 is hardwired to zero: writes and scoreboard marks to it are dropped.
//
// Ports
//   clk            clock; every state update happens on its rising edge
//   rst            synchronous, active-high reset (restarts the clear walk)
//   init_done_o    1 once the clear walk has zeroed every entry
//   rd_addr_i      read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data_o      read data,      port k = [k*DATA_W +: DATA_W]
//   rd_busy_o      scoreboard bit of each read address
//   wb_we_i        write port 0 enable (writeback, wins collisions)
//   wb_waddr_i     write port 0 address
//   wb_wdata_i     write port 0 data
//   ld_we_i        write port 1 enable (late load return)
//   ld_waddr_i     write port 1 address
//   ld_wdata_i     write port 1 data
//   sb_set_i       mark sb_set_addr_i as pending (its producer has issued)
//   sb_set_addr_i  destination register being marked
// ----------------------------------------------------------------------------
module regs_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done_o,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       wb_we_i,
    input  logic [ADDR_W-1:0]          wb_waddr_i,
    input  logic [DATA_W-1:0]          wb_wdata_i,
    input  logic                       ld_we_i,
    input  logic [ADDR_W-1:0]          ld_waddr_i,
    input  logic [DATA_W-1:0]          ld_wdata_i,
    input  logic                       sb_set_i,
    input  logic [ADDR_W-1:0]          sb_set_addr_i
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   clr_ptr_next;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    busy_next;

    logic                run;
    logic                wb_en;
    logic                ld_wr_en;
    logic                ld_clr_en;
    logic                set_en;

    // ------------------------------------------------------------------------
    // Write qualification. Nothing is accepted during the clear walk, and
    // anything aimed at entry 0 is dropped. A load colliding with a
    // writeback to the same register loses its data, but it still counts as
    // a write for the scoreboard (the wb write clears that bit anyway).
    // ------------------------------------------------------------------------
    assign run       = (state == RUN);
    assign wb_en     = run && wb_we_i && (wb_waddr_i != '0);
    assign ld_clr_en = run && ld_we_i && (ld_waddr_i != '0);
    assign ld_wr_en  = ld_clr_en && !(wb_we_i && (wb_waddr_i == ld_waddr_i));
    assign set_en    = run && sb_set_i && (sb_set_addr_i != '0);

    assign init_done_o = run;

    // ------------------------------------------------------------------------
    // FSM state register and clear pointer
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Next-state logic: walk the pointer across every entry, then settle in
    // RUN until the next reset.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        unique case (state)
            CLEAR: begin
                clr_ptr_next = clr_ptr + ADDR_W'(1);
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage array: one entry cleared per cycle while walking, then normal
    // two-port writes. wb_en and ld_wr_en never target the same entry.
    // ------------------------------------------------------------------------
    // NOTE: the array deliberately has no reset branch; the clear walk zeroes
    // it, which keeps reset fan-out off the storage and lets it map to RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wb_en) begin
                    mem[wb_waddr_i] <= wb_wdata_i;
                end
                if (ld_wr_en) begin
                    mem[ld_waddr_i] <= ld_wdata_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard. Writes retire a pending producer; an issue marks a new one.
    // When both hit the same register the newer producer (set) must win.
    // ------------------------------------------------------------------------
    // NOTE: blocking assignments in this combinational block are ordered on
    // purpose: the later set overrides the earlier clears of the same bit.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_waddr_i] = 1'b0;
        end
        if (ld_clr_en) begin
            busy_next[ld_waddr_i] = 1'b0;
        end
        if (set_en) begin
            busy_next[sb_set_addr_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. Combinational, zero latency. With bypass enabled a write
    // in flight this cycle is forwarded (wb before ld), and its retirement is
    // reflected in the busy bit unless a new producer is being marked at the
    // same address in the same cycle.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              wb_hit;
        logic              ld_hit;
        logic              set_hit;
        logic [DATA_W-1:0] data;
        logic              busy_bit;

        assign addr    = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign wb_hit  = BYPASS && wb_we_i && (wb_waddr_i == addr);
        assign ld_hit  = BYPASS && ld_we_i && (ld_waddr_i == addr);
        assign set_hit = sb_set_i && (sb_set_addr_i == addr);

        always_comb begin
            data     = '0;
            busy_bit = 1'b0;
            if (run && (addr != '0)) begin
                if (wb_hit) begin
                    data = wb_wdata_i;
                end else if (ld_hit) begin
                    data = ld_wdata_i;
                end else begin
                    data = mem[addr];
                end
                busy_bit = busy[addr] && !((wb_hit || ld_hit) && !set_hit);
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
        assign rd_busy_o[k]                  = busy_bit;
    end

endmodule
